// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: decides taken branches/jumps in EX, issues PC redirect and IF/ID, ID/EX squash.
// Latency: PCSrcE/RedirectPCE one cycle after the sampling edge; flush lasts FLUSH_CYCLES non-stalled cycles.
// Backpressure: StallE freezes the FSM and flush counter; inputs seen while flushing are wrong-path and ignored.
//
// Ports:
//   clk, rst               - clock (rising edge), synchronous active-low reset
//   ValidE, StallE         - EX valid / pipeline stall
//   BranchE, JumpE, JalrE  - EX control-flow class (JalrE has target priority)
//   funct3E                - branch condition select
//   ZeroE..OverFlowE       - ALU flags of A minus B
//   PCTargetE, ALUResultE  - branch/JAL target, JALR target
//   PCSrcE, RedirectPCE    - one-cycle redirect strobe and registered target
//   FlushD, FlushE, BusyE  - squash pulses and FSM-busy indicator
// Optional feature macro: BRU_PERF_CNT_EN adds BranchCntE / TakenCntE performance counters.
module branch_resolve_unit #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ValidE,
    input  logic            StallE,
    input  logic            BranchE,
    input  logic            JumpE,
    input  logic            JalrE,
    input  logic [2:0]      funct3E,
    input  logic            ZeroE,
    input  logic            NegativeE,
    input  logic            CarryE,
    input  logic            OverFlowE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic [XLEN-1:0] ALUResultE,
`ifdef BRU_PERF_CNT_EN
    output logic [31:0]     BranchCntE,
    output logic [31:0]     TakenCntE,
`endif
    output logic            PCSrcE,
    output logic [XLEN-1:0] RedirectPCE,
    output logic            FlushD,
    output logic            FlushE,
    output logic            BusyE
);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              pcsrc_q, pcsrc_d;
    logic              flush_q, flush_d;
    logic [XLEN-1:0]   redirect_q, redirect_d;

    logic              cond;
    logic              take;
    logic [XLEN-1:0]   target;

    // Flags come from A minus B: signed less-than is N^V, unsigned less-than is a clear carry (no borrow-out).
    always_comb begin
        cond = 1'b0;
        case (funct3E)
            3'b000:  cond = ZeroE;
            3'b001:  cond = ~ZeroE;
            3'b100:  cond = NegativeE ^ OverFlowE;
            3'b101:  cond = ~(NegativeE ^ OverFlowE);
            3'b110:  cond = ~CarryE;
            3'b111:  cond = CarryE;
            default: cond = 1'b0;
        endcase
    end

    assign take   = ValidE & (JalrE | JumpE | (BranchE & cond));
    assign target = JalrE ? {ALUResultE[XLEN-1:1], 1'b0} : PCTargetE;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pcsrc_d    = 1'b0;   // strobe lives for one cycle only, stall or not
        flush_d    = flush_q;
        redirect_d = redirect_q;
        case (state_q)
            IDLE: begin
                if (!StallE && take) begin
                    state_d    = FLUSH;
                    cnt_d      = 3'(FLUSH_CYCLES - 1);
                    pcsrc_d    = 1'b1;
                    flush_d    = 1'b1;
                    redirect_d = target;
                end
            end
            FLUSH: begin
                flush_d = 1'b1;
                if (!StallE) begin
                    if (cnt_q == 3'd0) begin
                        state_d = IDLE;
                        flush_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                flush_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            pcsrc_q    <= 1'b0;
            flush_q    <= 1'b0;
            redirect_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pcsrc_q    <= pcsrc_d;
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
        end
    end

    assign PCSrcE      = pcsrc_q;
    assign RedirectPCE = redirect_q;
    assign FlushD      = flush_q;
    assign FlushE      = flush_q;
    assign BusyE       = (state_q == FLUSH);

`ifdef BRU_PERF_CNT_EN
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] tk_cnt_q, tk_cnt_d;
    logic        accept;

    // Only right-path control-flow instructions seen by the idle FSM are counted.
    assign accept = (state_q == IDLE) & ~StallE & ValidE & (BranchE | JumpE | JalrE);

    always_comb begin
        br_cnt_d = br_cnt_q;
        tk_cnt_d = tk_cnt_q;
        if (accept)
            br_cnt_d = br_cnt_q + 32'd1;
        if (accept && take)
            tk_cnt_d = tk_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            br_cnt_q <= '0;
            tk_cnt_q <= '0;
        end else begin
            br_cnt_q <= br_cnt_d;
            tk_cnt_q <= tk_cnt_d;
        end
    end

    assign BranchCntE = br_cnt_q;
    assign TakenCntE  = tk_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            ValidE, StallE, BranchE, JumpE, JalrE;
    logic [2:0]      funct3E;
    logic            ZeroE, NegativeE, CarryE, OverFlowE;
    logic [XLEN-1:0] PCTargetE, ALUResultE;
    logic            PCSrcE, FlushD, FlushE, BusyE;
    logic [XLEN-1:0] RedirectPCE;
`ifdef BRU_PERF_CNT_EN
    logic [31:0]     BranchCntE, TakenCntE;
`endif

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(XLEN), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .ValidE(ValidE), .StallE(StallE), .BranchE(BranchE), .JumpE(JumpE), .JalrE(JalrE),
        .funct3E(funct3E), .ZeroE(ZeroE), .NegativeE(NegativeE), .CarryE(CarryE),
        .OverFlowE(OverFlowE), .PCTargetE(PCTargetE), .ALUResultE(ALUResultE),
`ifdef BRU_PERF_CNT_EN
        .BranchCntE(BranchCntE), .TakenCntE(TakenCntE),
`endif
        .PCSrcE(PCSrcE), .RedirectPCE(RedirectPCE), .FlushD(FlushD), .FlushE(FlushE),
        .BusyE(BusyE)
    );

    typedef struct {
        string           tag;
        logic            pcsrc;
        logic [XLEN-1:0] redir;
        logic            flush;
        logic            busy;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input string fld, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s.%s observed=0x%0h expected=0x%0h", tag, fld, obs, expv);
        end
    endtask

    // Push the outputs expected after the coming edge, clock it, then pop and compare.
    task automatic cyc(input string tag, input logic pcsrc, input logic [XLEN-1:0] redir,
                       input logic flush, input logic busy);
        exp_t e;
        e.tag = tag; e.pcsrc = pcsrc; e.redir = redir; e.flush = flush; e.busy = busy;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk(e.tag, "PCSrcE",      {31'd0, PCSrcE}, {31'd0, e.pcsrc});
        chk(e.tag, "RedirectPCE", RedirectPCE,     e.redir);
        chk(e.tag, "FlushD",      {31'd0, FlushD}, {31'd0, e.flush});
        chk(e.tag, "FlushE",      {31'd0, FlushE}, {31'd0, e.flush});
        chk(e.tag, "BusyE",       {31'd0, BusyE},  {31'd0, e.busy});
    endtask

    task automatic drive(input logic v, input logic br, input logic j, input logic jr,
                         input logic [2:0] f3, input logic z, input logic n, input logic c,
                         input logic o, input logic [XLEN-1:0] pct, input logic [XLEN-1:0] alu);
        ValidE = v; BranchE = br; JumpE = j; JalrE = jr; funct3E = f3;
        ZeroE = z; NegativeE = n; CarryE = c; OverFlowE = o;
        PCTargetE = pct; ALUResultE = alu;
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // Inputs already driven for a taken instruction: check the full redirect + 2-cycle flush.
    task automatic redirect_seq(input string tag, input logic [XLEN-1:0] tgt);
        cyc(tag, 1'b1, tgt, 1'b1, 1'b1);
        idle_in();
        cyc(tag, 1'b0, tgt, 1'b1, 1'b1);
        cyc(tag, 1'b0, tgt, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; StallE = 1'b0;
        idle_in();
        @(negedge clk);
        cyc("reset0", 1'b0, 32'h0, 1'b0, 1'b0);
        cyc("reset1", 1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        cyc("idle", 1'b0, 32'h0, 1'b0, 1'b0);

        // BEQ taken
        drive(1, 1, 0, 0, 3'b000, 1, 0, 0, 0, 32'h100, 32'h0);
        redirect_seq("beq", 32'h100);

        // BLT with N=1,V=1 -> not less
        drive(1, 1, 0, 0, 3'b100, 0, 1, 0, 1, 32'h180, 32'h0);
        cyc("blt_nt", 1'b0, 32'h100, 1'b0, 1'b0);
        // BGE same flags -> taken
        drive(1, 1, 0, 0, 3'b101, 0, 1, 0, 1, 32'h1C0, 32'h0);
        redirect_seq("bge", 32'h1C0);
        // BLTU carry clear -> taken
        drive(1, 1, 0, 0, 3'b110, 0, 0, 0, 0, 32'h200, 32'h0);
        redirect_seq("bltu", 32'h200);
        // BGEU carry clear -> not taken
        drive(1, 1, 0, 0, 3'b111, 0, 0, 0, 0, 32'h240, 32'h0);
        cyc("bgeu_nt", 1'b0, 32'h200, 1'b0, 1'b0);
        // funct3 010/011 never taken
        drive(1, 1, 0, 0, 3'b010, 1, 1, 1, 1, 32'h250, 32'h0);
        cyc("f3_010", 1'b0, 32'h200, 1'b0, 1'b0);
        drive(1, 1, 0, 0, 3'b011, 1, 1, 1, 1, 32'h260, 32'h0);
        cyc("f3_011", 1'b0, 32'h200, 1'b0, 1'b0);
        // ValidE=0 blocks everything
        drive(0, 1, 1, 1, 3'b000, 1, 0, 0, 0, 32'h270, 32'h273);
        cyc("invalid", 1'b0, 32'h200, 1'b0, 1'b0);

        // JALR + JAL + branch together -> JALR target with bit0 cleared
        drive(1, 1, 1, 1, 3'b000, 1, 0, 0, 0, 32'h999, 32'h203);
        redirect_seq("jalr", 32'h202);
        // JAL alone
        drive(1, 0, 1, 0, 3'b010, 0, 0, 0, 0, 32'h2A0, 32'h0);
        redirect_seq("jal", 32'h2A0);

        // BNE taken, then a taken BNE held through the flush: ignored until the edge after return to IDLE
        drive(1, 1, 0, 0, 3'b001, 0, 0, 0, 0, 32'h300, 32'h0);
        cyc("bne", 1'b1, 32'h300, 1'b1, 1'b1);
        drive(1, 1, 0, 0, 3'b001, 0, 0, 0, 0, 32'h444, 32'h0);
        cyc("wrongpath", 1'b0, 32'h300, 1'b1, 1'b1);
        cyc("b2b_ignored", 1'b0, 32'h300, 1'b0, 1'b0);
        redirect_seq("b2b_accept", 32'h444);

        // Stall in the second flush cycle for 3 cycles
        drive(1, 1, 0, 0, 3'b000, 1, 0, 0, 0, 32'h500, 32'h0);
        cyc("st_take", 1'b1, 32'h500, 1'b1, 1'b1);
        idle_in();
        cyc("st_fl2", 1'b0, 32'h500, 1'b1, 1'b1);
        StallE = 1'b1;
        drive(1, 1, 0, 0, 3'b001, 0, 0, 0, 0, 32'h555, 32'h0);
        for (int i = 0; i < 3; i++) cyc("st_hold", 1'b0, 32'h500, 1'b1, 1'b1);
        StallE = 1'b0;
        cyc("st_end", 1'b0, 32'h500, 1'b0, 1'b0);
        idle_in();

        // Stall in the first flush cycle: strobe still drops, count frozen
        drive(1, 1, 0, 0, 3'b000, 1, 0, 0, 0, 32'h580, 32'h0);
        cyc("st1_take", 1'b1, 32'h580, 1'b1, 1'b1);
        idle_in();
        StallE = 1'b1;
        cyc("st1_hold", 1'b0, 32'h580, 1'b1, 1'b1);
        StallE = 1'b0;
        cyc("st1_fl2", 1'b0, 32'h580, 1'b1, 1'b1);
        cyc("st1_end", 1'b0, 32'h580, 1'b0, 1'b0);

        // Stall in IDLE holds a taken branch off
        StallE = 1'b1;
        drive(1, 0, 1, 0, 3'b000, 0, 0, 0, 0, 32'h5C0, 32'h0);
        cyc("idle_stall", 1'b0, 32'h580, 1'b0, 1'b0);
        StallE = 1'b0;
        redirect_seq("idle_unstall", 32'h5C0);

        // Reset in the first flush cycle
        drive(1, 1, 0, 0, 3'b000, 1, 0, 0, 0, 32'h600, 32'h0);
        cyc("rst_take", 1'b1, 32'h600, 1'b1, 1'b1);
        rst = 1'b0;
        cyc("rst_mid", 1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        drive(1, 1, 0, 0, 3'b000, 1, 0, 0, 0, 32'h700, 32'h0);
        redirect_seq("after_rst", 32'h700);

`ifdef BRU_PERF_CNT_EN
        rst = 1'b0;
        idle_in();
        cyc("perf_rst", 1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        chk("perf_rst", "BranchCntE", BranchCntE, 32'd0);
        chk("perf_rst", "TakenCntE",  TakenCntE,  32'd0);
        drive(1, 1, 0, 0, 3'b000, 1, 0, 0, 0, 32'h800, 32'h0);  // taken
        redirect_seq("p1", 32'h800);
        drive(1, 1, 0, 0, 3'b001, 1, 0, 0, 0, 32'h810, 32'h0);  // not taken
        cyc("p2", 1'b0, 32'h800, 1'b0, 1'b0);
        drive(1, 0, 1, 0, 3'b000, 0, 0, 0, 0, 32'h820, 32'h0);  // taken
        redirect_seq("p3", 32'h820);
        drive(1, 1, 0, 0, 3'b111, 0, 0, 0, 0, 32'h830, 32'h0);  // not taken
        cyc("p4", 1'b0, 32'h820, 1'b0, 1'b0);
        drive(1, 0, 0, 1, 3'b000, 0, 0, 0, 0, 32'h0, 32'h841);  // taken
        redirect_seq("p5", 32'h840);
        chk("perf", "BranchCntE", BranchCntE, 32'd5);
        chk("perf", "TakenCntE",  TakenCntE,  32'd3);
`endif

        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-stage consumer of the ALU status flags (Zero, Negative, Carry, OverFlow) produced by a SUB-class compare.
- Decides whether a branch or jump resolved in EX is taken, and issues the registered PC redirect plus the IF/ID and ID/EX squash pulses.
- Prediction is static not-taken, so every taken branch or jump costs a redirect and a flush sequence.

Parameters:
- XLEN, 32: PC and target width.
- FLUSH_CYCLES, 2: number of consecutive cycles FlushD/FlushE stay asserted per redirect; legal range 1..7.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- ValidE  input  1  EX-stage instruction is valid (not a bubble).
- StallE  input  1  pipeline stall; freezes FSM, counter and inputs sampling.
- BranchE  input  1  conditional branch in EX.
- JumpE  input  1  JAL in EX.
- JalrE  input  1  JALR in EX; takes priority over JumpE.
- funct3E  input  3  branch condition select.
- ZeroE, NegativeE, CarryE, OverFlowE  input  1 each  ALU flags from A minus B.
- PCTargetE  input  XLEN  PC plus immediate (branch/JAL target).
- ALUResultE  input  XLEN  rs1 plus immediate (JALR target).
- PCSrcE  output  1  one-cycle redirect strobe to the PC mux.
- RedirectPCE  output  XLEN  registered redirect target.
- FlushD  output  1  squash IF/ID register.
- FlushE  output  1  squash ID/EX register.
- BusyE  output  1  FSM not in IDLE.

Behaviour:
- Reset: when rst is 0 at a rising edge, state goes to IDLE. PCSrcE, FlushD, FlushE and BusyE are 0. RedirectPCE is 0. The flush counter is 0. Reset overrides everything, including mid-flush.
- Condition decode is combinational on the EX inputs; the resulting taken bit is TakeE:
  - 000 BEQ: Zero.
  - 001 BNE: not Zero.
  - 100 BLT: Negative xor OverFlow.
  - 101 BGE: not (Negative xor OverFlow).
  - 110 BLTU: not Carry.
  - 111 BGEU: Carry.
  - 010 and 011 are never taken.
- TakeE = ValidE and (JalrE or JumpE or (BranchE and condition)).
- Target selection: if JalrE, target = ALUResultE with bit 0 cleared. Otherwise target = PCTargetE.
- IDLE state:
  - If StallE=1, hold.
  - Else if TakeE=1, at the next edge: RedirectPCE <= target, PCSrcE <= 1, FlushD <= 1, FlushE <= 1, counter <= FLUSH_CYCLES-1, state <= FLUSH.
  - Else all strobes stay 0.
- FLUSH state:
  - BusyE=1 and FlushD=FlushE=1 throughout.
  - PCSrcE is high only in the first FLUSH cycle and is forced to 0 afterwards, even if StallE=1.
  - Each non-stalled edge: if counter=0, go to IDLE with flushes cleared; else decrement the counter.
  - StallE=1 freezes the counter and keeps the flushes asserted.
  - All branch inputs are ignored as wrong-path, even when TakeE=1.
- Latency: one cycle from the TakeE sampling edge to PCSrcE. The flush lasts exactly FLUSH_CYCLES non-stalled cycles.
- RedirectPCE holds its value until the next redirect.
- Back-to-back: a taken branch presented on the edge that returns FLUSH to IDLE is ignored. The first acceptable one is on the following edge.
- Simultaneous BranchE, JumpE and JalrE: JalrE target wins, and the redirect is taken.
- When ValidE=0, nothing is taken, regardless of the flags.

Optional Feature:
- Macro: BRU_PERF_CNT_EN.
- With the macro defined:
  - Adds ports BranchCntE (output, 32) and TakenCntE (output, 32), both reset to 0.
  - BranchCntE increments on each accepted IDLE non-stalled edge where ValidE and (BranchE or JumpE or JalrE) is 1.
  - TakenCntE increments on each redirect start.
  - Both wrap from 0xFFFFFFFF to 0.
- Without the macro: the ports and counters are absent, and all other behaviour is identical.

Test Plan:
- BEQ, funct3=000, Zero=1, PCTargetE=0x00000100, ValidE=1 -> next cycle PCSrcE=1, RedirectPCE=0x100. FlushD/FlushE high 2 cycles, then BusyE=0.
- BLT with Negative=1, OverFlow=1 -> not taken, no strobes. BLTU with Carry=0 -> taken. BGEU with Carry=0 -> not taken.
- JALR with ALUResultE=0x00000203 and JumpE=1 simultaneously -> RedirectPCE=0x00000202.
- Taken branch, then StallE=1 during the second flush cycle for 3 cycles -> FlushD/FlushE stay high, PCSrcE stays low, and flush ends 1 cycle after StallE drops. A taken BNE presented during FLUSH is ignored.
- rst=0 asserted in the first FLUSH cycle -> next edge all outputs are 0 and state is IDLE. A taken branch the cycle after rst releases redirects normally.
- With BRU_PERF_CNT_EN: 5 branches, 3 taken, preload TakenCntE near wrap via 0xFFFFFFFE redirects-equivalent forcing -> BranchCntE=5, TakenCntE wraps to 1.
